// File: rtl/arbitro_pkg.sv
// ---------------------------------------------------------------------------
// arbitro_pkg
// Shared definitions for the round-robin arbiter that time-shares a single
// Moore FSM between several requesters.
//   estado_t        : arbiter control states (idle, granted, release/settle)
//   N_PADRAO        : default number of requesters
//   MAX_HOLD_PADRAO : default maximum consecutive cycles a grant may be held
// ---------------------------------------------------------------------------
package arbitro_pkg;

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      CONCEDIDO = 2'd1,
      LIBERA    = 2'd2
   } estado_t;

   localparam int N_PADRAO        = 4;
   localparam int MAX_HOLD_PADRAO = 8;

endpackage

// File: rtl/seletor_rr.sv
// ---------------------------------------------------------------------------
// seletor_rr
// Combinational rotating-priority search. Starting at index ptr and walking
// upwards (wrapping N-1 -> 0), returns the first requester with req set.
//   req    : request vector, one bit per requester
//   ptr    : index holding highest priority this round
//   valido : high when at least one request is present
//   idx    : index of the winning requester (0 when valido is low)
// ---------------------------------------------------------------------------
module seletor_rr #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valido,
   output logic [W-1:0] idx
);

   // Scan offsets from farthest to nearest so the candidate closest to ptr
   // is the last one written and therefore wins.
   always_comb begin
      int j;
      valido = 1'b0;
      idx    = '0;
      j      = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            valido = 1'b1;
            idx    = W'(j);
         end
      end
   end

endmodule

// File: rtl/arbitro_rr.sv
// ---------------------------------------------------------------------------
// arbitro_rr
// Round-robin arbiter sharing one Moore FSM (maquina_estados) between N
// requesters. One requester owns the FSM at a time; its pulse is muxed onto
// the FSM input and the FSM output is returned to it alone. A grant is held
// for at most MAX_HOLD cycles, and every release is followed by two idle
// cycles so the shared FSM settles before the next owner.
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   req[N]      : level-sensitive request per requester
//   pulso[N]    : per-requester pulse destined for the shared FSM
//   saida_fsm   : output of the shared FSM
//   gnt[N]      : registered one-hot grant
//   gnt_id[W]   : registered index of current/last granted requester
//   entrada_fsm : input to the shared FSM
//   saida_req[N]: FSM output routed to the granted requester
//   ocupado     : high while a grant is active
//   estouro     : one-cycle flag when a grant is revoked by hold timeout
// ---------------------------------------------------------------------------
module arbitro_rr
   import arbitro_pkg::*;
#(
   parameter  int N        = N_PADRAO,
   parameter  int MAX_HOLD = MAX_HOLD_PADRAO,
   localparam int W        = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic [N-1:0] pulso,
   input  logic         saida_fsm,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_id,
   output logic         entrada_fsm,
   output logic [N-1:0] saida_req,
   output logic         ocupado,
   output logic         estouro
);

   localparam int CW = $clog2(MAX_HOLD) + 1;

   estado_t         estado;
   estado_t         estado_prox;
   logic [W-1:0]    ptr;
   logic [CW-1:0]   cont;
   logic            valido;
   logic [W-1:0]    idx;
   logic            fim_hold;

   seletor_rr #(.N(N)) u_seletor (
      .req    (req),
      .ptr    (ptr),
      .valido (valido),
      .idx    (idx)
   );

   // The owner has used its last allowed cycle when cont reaches MAX_HOLD-1.
   assign fim_hold = (cont == CW'(MAX_HOLD - 1));

   // State register; reset wins over everything, including a live grant.
   always_ff @(posedge clk) begin
      if (rst) estado <= OCIOSO;
      else     estado <= estado_prox;
   end

   // Next-state logic. LIBERA always falls back to OCIOSO, which gives the
   // two grant-free settle cycles between owners.
   always_comb begin
      estado_prox = estado;
      case (estado)
         OCIOSO:    if (valido) estado_prox = CONCEDIDO;
         CONCEDIDO: if (!req[gnt_id] || fim_hold) estado_prox = LIBERA;
         LIBERA:    estado_prox = OCIOSO;
         default:   estado_prox = OCIOSO;
      endcase
   end

   // Grant bookkeeping. The pointer only advances in LIBERA, so a timed-out
   // requester that keeps asking drops to lowest priority next round.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt     <= '0;
         gnt_id  <= '0;
         ptr     <= '0;
         cont    <= '0;
         estouro <= 1'b0;
      end else begin
         estouro <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (valido) begin
                  gnt    <= N'(1) << idx;
                  gnt_id <= idx;
                  cont   <= '0;
               end
            end
            CONCEDIDO: begin
               if (!req[gnt_id]) begin
                  gnt <= '0;
               end else if (fim_hold) begin
                  gnt     <= '0;
                  estouro <= 1'b1;
               end else begin
                  cont <= cont + CW'(1);
               end
            end
            LIBERA: begin
               gnt <= '0;
               ptr <= (gnt_id == W'(N - 1)) ? '0 : gnt_id + W'(1);
            end
            default: gnt <= '0;
         endcase
      end
   end

   // Routing to and from the shared FSM: only the owner is connected, and
   // pulses from everyone else are simply dropped.
   always_comb begin
      ocupado     = (estado == CONCEDIDO);
      entrada_fsm = 1'b0;
      saida_req   = '0;
      if (ocupado) begin
         entrada_fsm       = pulso[gnt_id];
         saida_req[gnt_id] = saida_fsm;
      end
   end

endmodule

// File: doc/arbitro_rr.md
Name: arbitro_rr

Overview:
- Round-robin arbiter/scheduler that shares one `maquina_estados` instance (single-bit pulse input `entrada`, single-bit Moore output `saida`) between N requesters.
- Grants exclusive access to one requester at a time.
- Muxes the granted requester's pulse onto the shared FSM input and routes the FSM output back to that requester only.
- Enforces a maximum hold time so no requester can starve the others.

Parameters:
- N, 4, number of requesters (N ≥ 2).
- MAX_HOLD, 8, maximum consecutive cycles a grant is held (MAX_HOLD ≥ 1).
- W, $clog2(N), width of the grant index (derived, not overridable).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request vector, one bit per requester, level-sensitive.
- pulso  input  N  per-requester pulse destined for the shared FSM.
- saida_fsm  input  1  `saida` of the shared FSM.
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  W  index of current/last granted requester, registered.
- entrada_fsm  output  1  drives `entrada` of the shared FSM.
- saida_req  output  N  FSM output routed to the granted requester.
- ocupado  output  1  high while any grant is active.
- estouro  output  1  single-cycle flag when a grant is revoked by hold timeout.

Behaviour:
- All state updates on the rising edge of clk; reset is checked first, synchronously.
- Reset values: estado=OCIOSO, gnt=0, gnt_id=0, ptr=0, cont=0, estouro=0. Hence entrada_fsm=0, saida_req=0, ocupado=0.
- Reset asserted mid-grant drops gnt on that same edge. No LIBERA cycle is inserted.
- States:
  - OCIOSO: no grant. If |req at the edge → CONCEDIDO. Winner = first index i in order ptr, ptr+1, …, N-1, 0, …, ptr-1 with req[i]=1. Load gnt=1<<i, gnt_id=i, cont=0.
  - CONCEDIDO:
    - If req[gnt_id]=0 → LIBERA, estouro=0.
    - Else if cont==MAX_HOLD-1 → LIBERA, estouro=1 for exactly one cycle.
    - Else cont++.
  - LIBERA: gnt=0, ptr=(gnt_id+1) mod N; → OCIOSO unconditionally. estouro returns to 0 on leaving LIBERA.
- Grant latency: req sampled high in OCIOSO → gnt asserted the following cycle (1 cycle).
- Release latency: req drop sampled in CONCEDIDO → gnt low next cycle.
- Minimum gap between consecutive grants: 2 cycles with gnt=0 (LIBERA + OCIOSO). This is a deliberate settle time for the Moore FSM.
- Maximum gnt high duration: MAX_HOLD cycles.
- Combinational outputs:
  - entrada_fsm = pulso[gnt_id] when estado==CONCEDIDO, else 0. Pulses from non-granted requesters are dropped, not queued.
  - saida_req[i] = saida_fsm when estado==CONCEDIDO and i==gnt_id, else 0.
  - ocupado = (estado==CONCEDIDO).
- gnt_id holds its last value outside CONCEDIDO; it is only meaningful while ocupado=1.
- Timed-out requester that keeps req high stays eligible, but ptr has advanced past it, so it has lowest priority next round.
- Simultaneous requests resolve purely by ptr order. A req rising during LIBERA is seen in OCIOSO.
- ptr wraps N-1 → 0.
- cont width: $clog2(MAX_HOLD)+1 bits; never exceeds MAX_HOLD-1.
- Invariant: gnt is zero or one-hot at all times.

Decomposition:
- Shared package arbitro_pkg:
  - typedef enum logic [1:0] estado_t {OCIOSO, CONCEDIDO, LIBERA}.
  - Default constants N_PADRAO=4, MAX_HOLD_PADRAO=8.
- One sub-module, seletor_rr:
  - Purely combinational.
  - Inputs: req[N], ptr[W]. Outputs: valido, idx[W].
  - Rotating priority search. Instantiated once in arbitro_rr and unit-testable alone.

Test Plan:
All scenarios use N=4, MAX_HOLD=8.
1. Reset: assert rst 2 cycles with req=4'b1111 → gnt=0, ocupado=0, entrada_fsm=0 during and 1 cycle after; first grant gnt=4'b0001, gnt_id=0.
2. Single requester: req=4'b0100 for 3 cycles, pulso[2] pulsed once mid-grant → gnt=4'b0100 one cycle after req; entrada_fsm mirrors pulso[2] the same cycle; saida_req[2]=saida_fsm; gnt low the cycle after req drops.
3. Rotation: req=4'b1111, each requester drops req 2 cycles after its grant → grant order 0,1,2,3,0 with exactly 2 zero-gnt cycles between grants.
4. Timeout: req=4'b0011 held constantly → gnt=4'b0001 for exactly 8 cycles, estouro=1 for one cycle, then gnt=4'b0010 for 8 cycles, then 4'b0001 again.
5. Isolation: grant held by 1, pulso[3] toggling → entrada_fsm never reflects pulso[3]; saida_req[3]=0 throughout.
6. Reset mid-grant: rst asserted at cycle 3 of a grant to 2 → gnt=0 on that edge; after release, ptr=0 so req=4'b0101 grants 0 first.
